fetch_pc_queue: RTL and testbench

Instruction-fetch front end that sits directly upstream of rename-stage branch target resolution. It owns the fetch PC register and picks the next PC by fixed priority: commit redirect, then rename misdirect, then predictor target, then sequential PC. It issues word addresses to a synchronous instruction memory and buffers returned instructions, with their PC and predicted next PC, in a DEPTH-entry queue. The queue drains into rename through a valid/ready handshake. Its deqPC/deqPredPC outputs are the PC/predictedPC operands of the target-resolve logic, whose misdirect/validAddress feed back as renameMisdirect/renameTarget.

---
 rtl/fetch_pc_queue.sv | 118 +++++++++++
 tb/tb_fetch_pc_queue.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_pc_queue.sv
// Fetch front end: selects the next fetch PC, issues word reads to a synchronous
// instruction memory and buffers the returned instructions for rename.
module fetch_pc_queue #(
    parameter int             WIDTH    = 31,
    parameter int             DEPTH    = 4,
    parameter logic [WIDTH:0] RESET_PC = '0
) (
    input  logic           clk,
    input  logic           resetN,
    input  logic           commitRedirect,
    input  logic [WIDTH:0] commitTarget,
    input  logic           renameMisdirect,
    input  logic [WIDTH:0] renameTarget,
    input  logic           predTaken,
    input  logic [WIDTH:0] predTarget,
    output logic [WIDTH:0] fetchPC,
    output logic           fetchValid,
    input  logic [WIDTH:0] imemInstr,
    output logic           deqValid,
    input  logic           deqReady,
    output logic [WIDTH:0] deqInstr,
    output logic [WIDTH:0] deqPC,
    output logic [WIDTH:0] deqPredPC,
    output logic           deqPredTaken
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0]    DEPTH_C = (CW+1)'(DEPTH);
    localparam logic [WIDTH:0] PC_ONE  = (WIDTH+1)'(1);
    localparam logic [PW-1:0]  PTR_ONE = PW'(1);
    localparam logic [CW-1:0]  CNT_ONE = CW'(1);

    typedef struct packed {
        logic [WIDTH:0] instr;
        logic [WIDTH:0] pc;
        logic [WIDTH:0] pred_pc;
        logic           pred_taken;
    } entry_t;

    entry_t         mem [DEPTH];
    logic [WIDTH:0] fetch_pc;
    logic           resp_valid;
    logic [WIDTH:0] resp_pc;
    logic [WIDTH:0] resp_pred_pc;
    logic           resp_pred_taken;
    logic [CW-1:0]  count;
    logic [PW-1:0]  wr_ptr;
    logic [PW-1:0]  rd_ptr;

    logic [CW:0]    occ;
    logic           issue;
    logic           flush;
    logic           enq;
    logic           deq;
    logic [WIDTH:0] pred_next;
    logic [WIDTH:0] pc_next;

    // The in-flight read counts as occupied so its response always has a slot.
    always_comb begin
        occ       = {1'b0, count} + {{CW{1'b0}}, resp_valid};
        issue     = resetN && (occ < DEPTH_C);
        flush     = commitRedirect | renameMisdirect;
        enq       = resp_valid & ~flush;
        deq       = deqValid & deqReady;
        pred_next = predTaken ? predTarget : fetch_pc + PC_ONE;
        pc_next   = pred_next;
        if (commitRedirect)       pc_next = commitTarget;
        else if (renameMisdirect) pc_next = renameTarget;
        else if (!issue)          pc_next = fetch_pc;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            fetch_pc        <= RESET_PC;
            resp_valid      <= 1'b0;
            resp_pc         <= '0;
            resp_pred_pc    <= '0;
            resp_pred_taken <= 1'b0;
            count           <= '0;
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            fetch_pc   <= pc_next;
            resp_valid <= issue & ~flush;
            if (issue) begin
                resp_pc         <= fetch_pc;
                resp_pred_pc    <= pred_next;
                resp_pred_taken <= predTaken;
            end
            if (flush) begin
                count  <= '0;
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (enq) begin
                    mem[wr_ptr] <= '{instr: imemInstr, pc: resp_pc,
                                     pred_pc: resp_pred_pc, pred_taken: resp_pred_taken};
                    wr_ptr <= wr_ptr + PTR_ONE;
                end
                if (deq) rd_ptr <= rd_ptr + PTR_ONE;
                case ({enq, deq})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    assign fetchPC      = fetch_pc;
    assign fetchValid   = issue;
    assign deqValid     = (count != '0);
    assign deqInstr     = mem[rd_ptr].instr;
    assign deqPC        = mem[rd_ptr].pc;
    assign deqPredPC    = mem[rd_ptr].pred_pc;
    assign deqPredTaken = mem[rd_ptr].pred_taken;
endmodule

// File: tb/tb_fetch_pc_queue.sv
// Bench for fetch_pc_queue: directed scenarios with literal expectations, then
// random traffic compared every cycle against a queue-based reference model.
module tb_fetch_pc_queue;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetN;
    logic        commitRedirect, renameMisdirect, predTaken, deqReady;
    logic [31:0] commitTarget, renameTarget, predTarget, imemInstr;
    logic [31:0] fetchPC, deqInstr, deqPC, deqPredPC;
    logic        fetchValid, deqValid, deqPredTaken;

    int n_tests = 0;
    int n_fail  = 0;

    fetch_pc_queue #(.WIDTH(31), .DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk(clk), .resetN(resetN),
        .commitRedirect(commitRedirect), .commitTarget(commitTarget),
        .renameMisdirect(renameMisdirect), .renameTarget(renameTarget),
        .predTaken(predTaken), .predTarget(predTarget),
        .fetchPC(fetchPC), .fetchValid(fetchValid), .imemInstr(imemInstr),
        .deqValid(deqValid), .deqReady(deqReady), .deqInstr(deqInstr),
        .deqPC(deqPC), .deqPredPC(deqPredPC), .deqPredTaken(deqPredTaken)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] imem_fn(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Synchronous instruction memory: data for the address presented this cycle.
    always @(posedge clk) imemInstr <= imem_fn(fetchPC);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a PC, an optional in-flight read and a queue of entries.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic [31:0] pred_pc;
        logic        pt;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = 0;
    bit          fly_v = 0;
    logic [31:0] fly_pc, fly_pp;
    logic        fly_pt;

    always @(posedge clk) begin
        bit          m_issue;
        logic [31:0] nxt;
        ent_t        e;
        if (!resetN) begin
            m_pc = 0; q.delete(); fly_v = 0;
        end else begin
            m_issue = (q.size() + int'(fly_v)) < DEPTH;
            nxt = predTaken ? predTarget : m_pc + 1;
            if (commitRedirect || renameMisdirect) begin
                q.delete(); fly_v = 0;
            end else begin
                if (q.size() != 0 && deqReady) void'(q.pop_front());
                if (fly_v) begin
                    e.instr = imem_fn(fly_pc); e.pc = fly_pc; e.pred_pc = fly_pp; e.pt = fly_pt;
                    q.push_back(e);
                end
                fly_v = m_issue;
                if (m_issue) begin fly_pc = m_pc; fly_pp = nxt; fly_pt = predTaken; end
            end
            if (commitRedirect)       m_pc = commitTarget;
            else if (renameMisdirect) m_pc = renameTarget;
            else if (m_issue)         m_pc = nxt;
        end
    end

    always @(negedge clk) begin
        chk("fetchPC", fetchPC, m_pc);
        chk("fetchValid", 32'(fetchValid), 32'(resetN && (q.size() + int'(fly_v)) < DEPTH));
        chk("deqValid", 32'(deqValid), 32'(q.size() != 0));
        if (q.size() != 0) begin
            chk("deqInstr", deqInstr, q[0].instr);
            chk("deqPC", deqPC, q[0].pc);
            chk("deqPredPC", deqPredPC, q[0].pred_pc);
            chk("deqPredTaken", 32'(deqPredTaken), 32'(q[0].pt));
        end else if (!resetN) begin
            chk("rst_deqPC", deqPC, 32'h0);
            chk("rst_deqPredPC", deqPredPC, 32'h0);
            chk("rst_deqInstr", deqInstr, 32'h0);
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    initial begin
        resetN = 1'b0; commitRedirect = 0; renameMisdirect = 0; predTaken = 0; deqReady = 1;
        commitTarget = 0; renameTarget = 0; predTarget = 0;
        repeat (2) step();
        chk("rst_fetchValid", 32'(fetchValid), 32'h0);
        chk("rst_deqValid", 32'(deqValid), 32'h0);

        // Sequential streaming from reset
        resetN = 1'b1; #1;
        chk("t1_pc0", fetchPC, 32'h0);
        chk("t1_fv0", 32'(fetchValid), 32'h1);
        step(); chk("t1_pc1", fetchPC, 32'h1); chk("t1_dv1", 32'(deqValid), 32'h0);
        step(); chk("t1_pc2", fetchPC, 32'h2); chk("t1_dv2", 32'(deqValid), 32'h1);
        chk("t1_dpc", deqPC, 32'h0); chk("t1_dpp", deqPredPC, 32'h1);
        step(); chk("t1_dpc1", deqPC, 32'h1);

        // Backpressure: exactly PCs 0..3 issue, then one pulse frees one slot
        resetN = 0; deqReady = 0; step(); resetN = 1;
        repeat (4) step();
        chk("t2_pc4", fetchPC, 32'h4); chk("t2_fv", 32'(fetchValid), 32'h0);
        step();
        chk("t2_hold", fetchPC, 32'h4); chk("t2_fv2", 32'(fetchValid), 32'h0); chk("t2_head", deqPC, 32'h0);
        deqReady = 1; step(); deqReady = 0;
        chk("t2_resume", 32'(fetchValid), 32'h1); chk("t2_head1", deqPC, 32'h1);
        step(); chk("t2_pc5", fetchPC, 32'h5); chk("t2_fv3", 32'(fetchValid), 32'h0);

        // Predicted-taken at PC 2
        resetN = 0; deqReady = 1; step(); resetN = 1;
        step(); step(); chk("t3_pc2", fetchPC, 32'h2);
        predTaken = 1; predTarget = 32'h40; step(); predTaken = 0;
        chk("t3_pc40", fetchPC, 32'h40); chk("t3_d1", deqPC, 32'h1); chk("t3_d1pp", deqPredPC, 32'h2);
        step(); chk("t3_d2", deqPC, 32'h2); chk("t3_d2pp", deqPredPC, 32'h40);
        chk("t3_d2pt", 32'(deqPredTaken), 32'h1);
        step(); chk("t3_d40", deqPC, 32'h40); chk("t3_d40pp", deqPredPC, 32'h41);

        // Rename misdirect with 3 queued + 1 in flight
        resetN = 0; deqReady = 0; step(); resetN = 1;
        repeat (4) step();
        chk("t4_dv", 32'(deqValid), 32'h1); chk("t4_fv", 32'(fetchValid), 32'h0);
        renameMisdirect = 1; renameTarget = 32'h80; step(); renameMisdirect = 0;
        chk("t4_pc", fetchPC, 32'h80); chk("t4_fv2", 32'(fetchValid), 32'h1); chk("t4_flush", 32'(deqValid), 32'h0);
        step(); chk("t4_dv2", 32'(deqValid), 32'h0);
        step(); chk("t4_dv3", 32'(deqValid), 32'h1); chk("t4_dpc", deqPC, 32'h80);

        // Commit redirect wins over simultaneous rename misdirect
        commitRedirect = 1; commitTarget = 32'h100; renameMisdirect = 1; renameTarget = 32'h80;
        step(); commitRedirect = 0; renameMisdirect = 0;
        chk("t5_pc", fetchPC, 32'h100); chk("t5_dv", 32'(deqValid), 32'h0);
        step(); step(); chk("t5_dpc", deqPC, 32'h100); chk("t5_dpp", deqPredPC, 32'h101);

        // Asynchronous reset with a full queue
        repeat (5) step();
        chk("t6_full", 32'(fetchValid), 32'h0); chk("t6_dv", 32'(deqValid), 32'h1);
        resetN = 0; #1;
        chk("t6_async_dv", 32'(deqValid), 32'h0); chk("t6_async_pc", fetchPC, 32'h0);
        chk("t6_async_fv", 32'(fetchValid), 32'h0); chk("t6_async_dpc", deqPC, 32'h0);
        deqReady = 1; step(); resetN = 1;
        step(); step(); chk("t6_dv2", 32'(deqValid), 32'h1); chk("t6_dpc", deqPC, 32'h0);

        // Random traffic
        repeat (3000) begin
            resetN          = ($urandom_range(0, 299) != 0);
            deqReady        = ($urandom_range(0, 3) != 0);
            predTaken       = ($urandom_range(0, 7) == 0);
            predTarget      = $urandom;
            commitRedirect  = ($urandom_range(0, 39) == 0);
            commitTarget    = $urandom;
            renameMisdirect = ($urandom_range(0, 24) == 0);
            renameTarget    = $urandom;
            step();
        end
        resetN = 1; commitRedirect = 0; renameMisdirect = 0; predTaken = 0;
        step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
